// File: rtl/start_stop_tx.sv
// rtl/start_stop_tx.sv - serial start/stop frame transmitter
//
// Shifts a parallel word out on a single wire as
// start(1), data LSB first, optional even parity, stop(0) x STOP_BITS.
// The line idles at 0. Every bit is held for CLKS_PER_BIT clocks.
//
// Ports:
//   clk    in   rising-edge clock
//   ar     in   asynchronous active-low reset
//   load   in   send request, taken only while ready=1
//   din    in   DATA_W word, sampled on the accepting edge
//   ready  out  1 = idle, load will be accepted
//   done   out  single-cycle pulse on return to idle after a full frame
//   x      out  serial line
module start_stop_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              ar,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    output logic              ready,
    output logic              done,
    output logic              x
);

    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                par_q, par_d;
    logic                x_q, x_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic                bit_end;

    assign bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            x_q     <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            x_q     <= x_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        x_d     = x_q;
        ready_d = 1'b0;
        done_d  = 1'b0;
        // Bit-cycle counter runs in every busy state and wraps at each bit change.
        cnt_d   = bit_end ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                idx_d   = '0;
                x_d     = 1'b0;
                ready_d = 1'b1;
                if (load) begin
                    state_d = START;
                    shift_d = din;
                    par_d   = ^din;
                    x_d     = 1'b1;
                    ready_d = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                    x_d     = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_W'(DATA_W - 1)) begin
                        idx_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            x_d     = par_q;
                        end else begin
                            state_d = STOP;
                            x_d     = 1'b0;
                        end
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = shift_q >> 1;
                        x_d     = shift_d[0];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    idx_d   = '0;
                    x_d     = 1'b0;
                end
            end
            STOP: begin
                x_d = 1'b0;
                if (bit_end) begin
                    // idx counts stop bits here; the data index is finished with.
                    if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                x_d     = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    assign x     = x_q;
    assign ready = ready_q;
    assign done  = done_q;

endmodule
